// File: rtl/shift_seq_pkg.sv
// Shared ALU definitions: shift op encodings, shifter state type and the
// ALU function-select codes used by the result multiplexer.
package shift_seq_pkg;

   // Shift operation encodings. op[0] picks right, op[1] picks arithmetic fill.
   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b11;

   // ALU function select, shared with the result multiplexer.
   localparam logic [2:0] ALU_FN_ADD   = 3'b000;
   localparam logic [2:0] ALU_FN_SUB   = 3'b001;
   localparam logic [2:0] ALU_FN_AND   = 3'b010;
   localparam logic [2:0] ALU_FN_OR    = 3'b011;
   localparam logic [2:0] ALU_FN_SHIFT = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } shift_state_t;

   // Right shift when op[0] is set.
   function automatic logic op_is_right(input logic [1:0] op);
      return op[0];
   endfunction

   // Sign fill applies only to right shifts with op[1] set.
   function automatic logic op_is_arith(input logic [1:0] op);
      return op[0] & op[1];
   endfunction

endpackage

// File: rtl/shift_seq_step.sv
// One iteration of the shifter: shifts by k in [0, STEP] using a small
// fixed-amount mux instead of a full barrel shifter.
module shift_seq_step
   import shift_seq_pkg::*;
#(
   parameter int SIZE = 32,
   parameter int STEP = 1,
   parameter int KW   = 6
)(
   input  logic [SIZE-1:0] data_i,
   input  logic [KW-1:0]   k_i,
   input  logic [1:0]      op_i,
   output logic [SIZE-1:0] data_o
);

   logic signed [SIZE-1:0] sdata_s;
   logic [SIZE-1:0]        cand_s [STEP+1];
   logic [SIZE-1:0]        sll_s  [STEP+1];
   logic [SIZE-1:0]        srl_s  [STEP+1];
   logic [SIZE-1:0]        sra_s  [STEP+1];

   assign sdata_s = $signed(data_i);

   // Candidate results for every legal step amount; sra is kept in its own
   // assignment so the signed operand is not turned unsigned by context.
   for (genvar i = 0; i <= STEP; i++) begin : g_cand
      assign sll_s[i]  = data_i << i;
      assign srl_s[i]  = data_i >> i;
      assign sra_s[i]  = sdata_s >>> i;
      assign cand_s[i] = op_is_right(op_i) ? (op_is_arith(op_i) ? sra_s[i] : srl_s[i])
                                           : sll_s[i];
   end

   // One-hot select of the candidate matching k.
   always_comb begin
      data_o = '0;
      for (int i = 0; i <= STEP; i++) begin
         data_o = data_o | (cand_s[i] & {SIZE{k_i == KW'(i)}});
      end
   end

endmodule

// File: rtl/shift_seq.sv
// Iterative SLL/SRL/SRA unit with start/busy/done handshake. The result
// register only changes on entry to DONE so the ALU mux input is stable.
module shift_seq
   import shift_seq_pkg::*;
#(
   parameter  int SIZE = 32,
   parameter  int STEP = 1,
   localparam int SHW  = $clog2(SIZE)
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [SIZE-1:0] operand,
   input  logic [SHW-1:0]  shamt,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] shift_r
);

   // k needs one extra bit so STEP itself (up to 8) is representable.
   localparam int          KW     = SHW + 1;
   localparam logic [KW-1:0] STEP_K = KW'(STEP);

   shift_state_t    state_q, state_d;
   logic [SIZE-1:0] work_q, work_d;
   logic [1:0]      op_q, op_d;
   logic [SHW-1:0]  rem_q, rem_d;
   logic [SIZE-1:0] result_q, result_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [KW-1:0]   k_s;
   logic [SIZE-1:0] step_s;

   // Step size for this cycle: the smaller of STEP and what is left.
   always_comb begin
      k_s = STEP_K;
      if ({1'b0, rem_q} < STEP_K) begin
         k_s = {1'b0, rem_q};
      end else begin
         k_s = STEP_K;
      end
   end

   shift_seq_step #(
      .SIZE (SIZE),
      .STEP (STEP),
      .KW   (KW)
   ) u_step (
      .data_i (work_q),
      .k_i    (k_s),
      .op_i   (op_q),
      .data_o (step_s)
   );

   // Next-state logic: accept a start in IDLE or DONE, iterate in SHIFT,
   // load the result only when DONE is entered.
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      op_d     = op_q;
      rem_d    = rem_q;
      result_d = result_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               work_d = operand;
               op_d   = op;
               rem_d  = shamt;
               if (shamt != '0) begin
                  state_d = SHIFT;
               end else begin
                  state_d  = DONE;
                  result_d = operand;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d = step_s;
            rem_d  = rem_q - k_s[SHW-1:0];
            if (rem_d == '0) begin
               state_d  = DONE;
               result_d = step_s;
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         work_q   <= '0;
         op_q     <= 2'b00;
         rem_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         op_q     <= op_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign shift_r = result_q;

endmodule

// File: doc/shift_seq.md
# shift_seq

Iterative shift unit for the execute stage, directly upstream of the ALU result multiplexer: it produces the shift result that the multiplexer selects when the ALU function is SHIFT. It implements SLL, SRL and SRA as a sequential shifter that moves STEP bit positions per cycle, with a start/busy/done handshake. The result is registered and held stable between operations so the multiplexer input never glitches.

## Interface
- SIZE, 32, datapath width; power of two, ≥ 8.
- STEP, 1, bit positions shifted per cycle; one of 1, 2, 4, 8, and ≤ SIZE.
- SHW, $clog2(SIZE), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  2  operation:
  - op[0]=1 selects a right shift, op[0]=0 a left shift.
  - op[1]=1 selects arithmetic fill, honoured only for right shifts.
  - Encodings: 00 SLL, 01 SRL, 11 SRA, 10 behaves as SLL.
- operand  in  SIZE  value to shift; sampled with start.
- shamt  in  SHW  shift amount; sampled with start.
- busy  out  1  high while shifting is in progress.
- done  out  1  one-cycle pulse; shift_r is valid in the same cycle.
- shift_r  out  SIZE  registered result; feeds the ALU result multiplexer.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset (any time, including mid-operation): the operation is aborted.
  - State goes to IDLE.
  - busy=0, done=0, shift_r=0.
  - Internal work register and remaining count are cleared.
- Start is accepted when start=1, busy=0 and the state is IDLE or DONE. On acceptance:
  - Latch operand into the work register.
  - Latch op.
  - Set rem=shamt.
  - Next state is SHIFT if shamt≠0, otherwise DONE.
- SHIFT, each cycle:
  - k = min(STEP, rem).
  - Work register shifts by k:
    - Left shifts fill with zeros.
    - SRL fills with zeros.
    - SRA fills with the latched sign bit.
  - rem -= k.
  - When rem becomes 0, the next state is DONE.
- Entering DONE: shift_r is loaded from the final work value. This load is the only time shift_r changes, apart from reset.
- DONE lasts exactly one cycle:
  - done=1.
  - Next state is IDLE, or SHIFT/DONE if a new start is accepted in that cycle (back-to-back operation).
- start while busy=1 is ignored: no queuing and no error.
- operand, op and shamt changing while busy have no effect.
- shift_r holds its last value through IDLE and through the whole next operation, until the next entry into DONE.

## Timing
- Let E0 be the edge at which start is accepted, and N = ceil(shamt/STEP).
- busy is high for exactly N cycles, starting in the cycle after E0. For shamt=0, busy never rises.
- done is high for one cycle, after edge E0+N. shift_r updates at that same edge.
- Latency from start to done is N+1 cycles, counting the start cycle. Minimum is 1 cycle after the start cycle, when shamt=0.
- Back-to-back: a start accepted during the done cycle begins immediately. busy rises in the following cycle, so there are no idle bubbles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared ALU package holds:
  - Shift op encodings: SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11.
  - State enum shift_state_t {IDLE, SHIFT, DONE}.
- The same package holds the ALU function select constants, shared with the result multiplexer, so that SHIFT=3'b100 is defined in one place.
- Sub-module shift_step: combinational, shifts a SIZE-bit value by k ∈ [0, STEP] in the direction and fill selected by op. It is instantiated once.
- The remaining-count register is SHW bits wide; it cannot underflow because k ≤ rem.

## Test plan
- SLL, operand 0x0000_0001, shamt 31, STEP=1 → busy high for 31 cycles, then done pulse with shift_r=0x8000_0000.
- SRA of 0x8000_0000 by 4 → shift_r=0xF800_0000 after 4 busy cycles. Then SRL of the same values → 0x0800_0000. Then op=10 with operand 1 → shift_r=0x0000_0010.
- shamt 0, operand 0xDEAD_BEEF → no busy cycle; done in the cycle after start; shift_r=0xDEAD_BEEF.
- start pulsed at cycle 2 of a 10-cycle SLL is ignored, and the result is correct. A new start in the done cycle is accepted, with busy rising in the next cycle.
- rst_n asserted mid-SHIFT → busy, done and shift_r go to 0 immediately. A new operation after release completes correctly.
- STEP=4, SLL of 0x1 by 7 → 2 busy cycles (steps of 4 then 3); shift_r=0x0000_0080.
